multi_sync_debounce: RTL and testbench

//   N-channel synchronizer/debouncer/edge detector for asynchronous inputs (keys, switches, external pulses).

---
 rtl/multi_sync_debounce.sv | 92 +++++++++
 tb/tb_multi_sync_debounce.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_sync_debounce.sv
// N-channel input conditioner: per-channel synchronizer chain, consecutive-sample
// debounce filter, and mode-selectable edge detector with sticky event flags.
module multi_sync_debounce #(
  parameter  int N_CH            = 4,
  parameter  int SYNC_STAGES     = 2,
  parameter  int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   in,
  input  logic [2*N_CH-1:0] edge_mode,
  input  logic [N_CH-1:0]   evt_clr,
  output logic [N_CH-1:0]   level,
  output logic [N_CH-1:0]   pulse,
  output logic [N_CH-1:0]   evt_flag
);

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   pulse_q;
    logic                   flag_q;
    logic                   s;
    logic                   accept;
    logic                   pulse_d;
    logic [1:0]             mode;

    assign s      = sync_q[SYNC_STAGES-1];
    assign accept = (s != level_q) && (cnt_q == CNT_MAX);
    assign mode   = edge_mode[2*c +: 2];

    // The new level equals s on the accepting edge, so s alone tells the edge direction.
    always_comb begin
      pulse_d = 1'b0;
      if (accept) begin
        case (mode)
          MODE_RISE: pulse_d = s;
          MODE_FALL: pulse_d = ~s;
          MODE_BOTH: pulse_d = 1'b1;
          default:   pulse_d = 1'b0;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], in[c]};
      end
    end

    // Any sample matching the current level restarts the count, rejecting glitches.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else if (s == level_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q   <= '0;
        level_q <= s;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    // A new event wins over a simultaneous clear so no event is ever lost.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pulse_q <= 1'b0;
        flag_q  <= 1'b0;
      end else begin
        pulse_q <= pulse_d;
        flag_q  <= pulse_d | (flag_q & ~evt_clr[c]);
      end
    end

    assign level[c]    = level_q;
    assign pulse[c]    = pulse_q;
    assign evt_flag[c] = flag_q;
  end

endmodule

// File: tb/tb_multi_sync_debounce.sv
// Directed-vector bench for multi_sync_debounce; expectations are queued with the
// cycle they are due and a negedge monitor compares them against the outputs.
module tb_multi_sync_debounce;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_raw;
  logic [7:0] edge_mode;
  logic [3:0] evt_clr;
  logic [3:0] level;
  logic [3:0] pulse;
  logic [3:0] evt_flag;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    string      name;
    int         which;   // 0 level, 1 pulse, 2 evt_flag
    logic [3:0] mask;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];

  multi_sync_debounce #(
    .N_CH(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in(in_raw),
    .edge_mode(edge_mode),
    .evt_clr(evt_clr),
    .level(level),
    .pulse(pulse),
    .evt_flag(evt_flag)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [3:0] act, logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endfunction

  function automatic void exp_at(int c, string nm, int which, logic [3:0] m, logic [3:0] v);
    exp_t e;
    e.cyc   = c;
    e.name  = nm;
    e.which = which;
    e.mask  = m;
    e.val   = v;
    sb.push_back(e);
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  logic [3:0] mon_act;
  bit         mon_pchk;

  always @(negedge clk) begin
    mon_pchk = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        mon_act = (sb[i].which == 0) ? level : (sb[i].which == 1) ? pulse : evt_flag;
        check(sb[i].name, mon_act & sb[i].mask, sb[i].val & sb[i].mask);
        if (sb[i].which == 1) mon_pchk = 1'b1;
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: due at cyc %0d never checked (now %0d)", sb[i].name, sb[i].cyc, cyc);
        sb.delete(i);
      end
    end
    // No pulse may appear on a cycle with no pulse expectation.
    if (!mon_pchk) check("no_spurious_pulse", pulse, 4'b0000);
  end

  int n;

  initial begin
    rst_n     = 1'b0;
    in_raw    = 4'b0000;
    edge_mode = 8'hFF;
    evt_clr   = 4'b0000;

    tick(2);
    n = cyc;
    exp_at(n + 1, "rst_level", 0, 4'hF, 4'h0);
    exp_at(n + 1, "rst_pulse", 1, 4'hF, 4'h0);
    exp_at(n + 1, "rst_flag",  2, 4'hF, 4'h0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // ch0 rise with full latency
    edge_mode = 8'hD0;
    in_raw[0] = 1'b1;
    n = cyc;
    exp_at(n + 5, "t1_level_pre", 0, 4'h1, 4'h0);
    exp_at(n + 5, "t1_pulse_pre", 1, 4'hF, 4'h0);
    exp_at(n + 6, "t1_level",     0, 4'hF, 4'h1);
    exp_at(n + 6, "t1_pulse",     1, 4'hF, 4'h1);
    exp_at(n + 6, "t1_flag",      2, 4'hF, 4'h1);
    exp_at(n + 7, "t1_pulse_end", 1, 4'hF, 4'h0);
    exp_at(n + 7, "t1_flag_hold", 2, 4'hF, 4'h1);
    tick(20);

    // ch1: sub-cycle glitch, 3-cycle glitch, then 4-cycle acceptance
    #10 in_raw[1] = 1'b1;
    #20 in_raw[1] = 1'b0;
    tick(1);
    n = cyc;
    exp_at(n + 8, "t2_tiny_glitch_level", 0, 4'h2, 4'h0);
    tick(10);

    n = cyc;
    in_raw[1] = 1'b1;
    exp_at(n + 6, "t2_short_level_a", 0, 4'h2, 4'h0);
    exp_at(n + 8, "t2_short_level_b", 0, 4'h2, 4'h0);
    tick(3);
    in_raw[1] = 1'b0;
    tick(10);

    n = cyc;
    in_raw[1] = 1'b1;
    exp_at(n + 5,  "t2_accept_pre",  0, 4'h2, 4'h0);
    exp_at(n + 6,  "t2_accept",      0, 4'h2, 4'h2);
    exp_at(n + 6,  "t2_pulse",       1, 4'hF, 4'h2);
    exp_at(n + 6,  "t2_flag",        2, 4'h2, 4'h2);
    exp_at(n + 7,  "t2_pulse_end",   1, 4'hF, 4'h0);
    exp_at(n + 9,  "t2_fall_pre",    0, 4'h2, 4'h2);
    exp_at(n + 10, "t2_fall",        0, 4'h2, 4'h0);
    tick(4);
    in_raw[1] = 1'b0;
    tick(12);

    // ch2 mode fall, then both, then none
    n = cyc;
    in_raw[2] = 1'b1;
    exp_at(n + 6, "t3_fall_mode_rise_lvl", 0, 4'h4, 4'h4);
    exp_at(n + 6, "t3_fall_mode_rise_pls", 1, 4'hF, 4'h0);
    tick(10);
    n = cyc;
    in_raw[2] = 1'b0;
    exp_at(n + 5, "t3_fall_pre",   0, 4'h4, 4'h4);
    exp_at(n + 6, "t3_fall_lvl",   0, 4'h4, 4'h0);
    exp_at(n + 6, "t3_fall_pls",   1, 4'hF, 4'h4);
    exp_at(n + 6, "t3_fall_flag",  2, 4'h4, 4'h4);
    exp_at(n + 7, "t3_fall_pend",  1, 4'hF, 4'h0);
    tick(10);

    edge_mode[5:4] = 2'b10;
    tick(3);
    n = cyc;
    in_raw[2] = 1'b1;
    exp_at(n + 6, "t3_both_rise_pls", 1, 4'hF, 4'h4);
    exp_at(n + 6, "t3_both_rise_lvl", 0, 4'h4, 4'h4);
    tick(10);
    n = cyc;
    in_raw[2] = 1'b0;
    exp_at(n + 6, "t3_both_fall_pls", 1, 4'hF, 4'h4);
    exp_at(n + 6, "t3_both_fall_lvl", 0, 4'h4, 4'h0);
    tick(10);

    edge_mode[5:4] = 2'b11;
    tick(3);
    n = cyc;
    in_raw[2] = 1'b1;
    exp_at(n + 6, "t3_none_rise_lvl", 0, 4'h4, 4'h4);
    exp_at(n + 6, "t3_none_rise_pls", 1, 4'hF, 4'h0);
    tick(10);
    n = cyc;
    in_raw[2] = 1'b0;
    exp_at(n + 6, "t3_none_fall_lvl", 0, 4'h4, 4'h0);
    exp_at(n + 6, "t3_none_fall_pls", 1, 4'hF, 4'h0);
    tick(10);

    // evt_clr alone, then evt_clr coinciding with a new ch0 event
    n = cyc;
    evt_clr[0] = 1'b1;
    exp_at(n + 1, "t4_clr_alone", 2, 4'hF, 4'b0110);
    tick(1);
    evt_clr[0] = 1'b0;
    in_raw[0]  = 1'b0;
    tick(10);

    n = cyc;
    in_raw[0] = 1'b1;
    exp_at(n + 5, "t4_flag_pre",   2, 4'hF, 4'b0110);
    exp_at(n + 6, "t4_pulse",      1, 4'hF, 4'b0001);
    exp_at(n + 6, "t4_set_wins",   2, 4'hF, 4'b0111);
    exp_at(n + 7, "t4_flag_hold",  2, 4'hF, 4'b0111);
    exp_at(n + 7, "t4_pulse_end",  1, 4'hF, 4'b0000);
    tick(5);
    evt_clr[0] = 1'b1;
    tick(1);
    evt_clr[0] = 1'b0;
    tick(6);

    // async reset mid-debounce on ch3, then full latency after release
    edge_mode[7:6] = 2'b00;
    in_raw[3] = 1'b1;
    tick(4);
    #20 rst_n = 1'b0;
    #1;
    check("t5_async_level", level,    4'h0);
    check("t5_async_pulse", pulse,    4'h0);
    check("t5_async_flag",  evt_flag, 4'h0);
    tick(3);
    rst_n = 1'b1;
    n = cyc;
    exp_at(n + 5, "t5_level_pre", 0, 4'hF, 4'b0000);
    exp_at(n + 6, "t5_level",     0, 4'hF, 4'b1001);
    exp_at(n + 6, "t5_pulse",     1, 4'hF, 4'b1001);
    exp_at(n + 6, "t5_flag",      2, 4'hF, 4'b1001);
    exp_at(n + 7, "t5_pulse_end", 1, 4'hF, 4'b0000);
    tick(10);

    // all channels rise together with modes {rise, fall, both, none}
    in_raw = 4'b0000;
    tick(10);
    n = cyc;
    evt_clr = 4'hF;
    exp_at(n + 1, "t6_clr_all", 2, 4'hF, 4'b0000);
    tick(1);
    evt_clr   = 4'h0;
    edge_mode = 8'hE4;
    n = cyc;
    in_raw = 4'hF;
    exp_at(n + 5, "t6_level_pre", 0, 4'hF, 4'b0000);
    exp_at(n + 6, "t6_level",     0, 4'hF, 4'b1111);
    exp_at(n + 6, "t6_pulse",     1, 4'hF, 4'b0101);
    exp_at(n + 6, "t6_flag",      2, 4'hF, 4'b0101);
    exp_at(n + 7, "t6_pulse_end", 1, 4'hF, 4'b0000);
    exp_at(n + 7, "t6_flag_hold", 2, 4'hF, 4'b0101);
    tick(10);

    if (sb.size() != 0) begin
      n_cmp += sb.size();
      n_bad += sb.size();
      $display("FAIL pending_expectations: got %0d left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
